sa_seq_ctrl: RTL and testbench

- Sequencer for one column of `sa_cell` spatial-array cells.
- Takes a start command and per-run configuration, aligns the cells' free-running 4-phase state machines, streams weights into each cell's move buffer, then feeds complex samples (real, imag) on the `left` bus in lock-step with the cell phases and flushes the pipeline.
- Sits between the host stream interfaces and the array column; owns the array's reset, mode and move-buffer write bus.

---
 rtl/sa_seq_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_sa_seq_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sa_seq_ctrl.sv
// Sequencer for one sa_cell array column: align, weight load, phase-locked sample feed, drain.
// Optional weight reuse across runs is enabled by defining SA_SEQ_CTRL_WEIGHT_REUSE_EN.
module sa_seq_ctrl #(
    parameter int DATA_WIDTH       = 32,
    parameter int MODE_WIDTH       = 1,
    parameter int N_ROWS           = 4,
    parameter int WEIGHTS_PER_CELL = 2,
    parameter int LEN_WIDTH        = 16,
    parameter int DRAIN_CYCLES     = N_ROWS + 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [MODE_WIDTH-1:0] cfg_mode,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
`ifdef SA_SEQ_CTRL_WEIGHT_REUSE_EN
    input  logic                  cfg_reuse_w,
`endif
    output logic                  busy,
    output logic                  done,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  w_valid,
    output logic                  w_ready,
    input  logic [DATA_WIDTH-1:0] x_data,
    input  logic                  x_valid,
    output logic                  x_ready,
    output logic                  arr_rst,
    output logic [MODE_WIDTH-1:0] arr_mode,
    output logic [DATA_WIDTH-1:0] arr_left,
    output logic [DATA_WIDTH-1:0] arr_move_data,
    output logic [N_ROWS-1:0]     arr_move_valid,
    output logic                  err_underrun
);

    localparam int ROW_W   = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam int IDX_W   = (WEIGHTS_PER_CELL > 1) ? $clog2(WEIGHTS_PER_CELL) : 1;
    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(N_ROWS - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(WEIGHTS_PER_CELL - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        LOAD,
        SYNC,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [1:0]            ph;
    logic [MODE_WIDTH-1:0] mode_q;
    logic [MODE_WIDTH-1:0] mode_src;
    logic [LEN_WIDTH-1:0]  samp_left;
    logic [ROW_W-1:0]      row_q;
    logic [IDX_W-1:0]      idx_q;
    logic [DRAIN_W-1:0]    drain_q;
    logic                  accept_start;
    logic                  reuse_ok;
    logic                  w_fire;
    logic                  x_fire;
    logic                  x_miss;
    logic                  last_word;
    logic                  group_end;

    assign accept_start = (state_q == IDLE) && start;
    assign w_fire       = w_ready && w_valid;
    assign x_fire       = x_ready && x_valid;
    assign x_miss       = x_ready && !x_valid;
    assign last_word    = (row_q == LAST_ROW) && (idx_q == LAST_IDX);
    assign group_end    = (ph == 2'd2);
    assign mode_src     = (state_q == IDLE) ? cfg_mode : mode_q;

`ifdef SA_SEQ_CTRL_WEIGHT_REUSE_EN
    logic aligned_q;

    // Reuse is only legal once the cells have been aligned and loaded since reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aligned_q <= 1'b0;
        end else if (state_q == ALIGN) begin
            aligned_q <= 1'b1;
        end
    end

    assign reuse_ok = cfg_reuse_w && aligned_q;
`else
    assign reuse_ok = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Leaving LOAD or SYNC is timed so that the first RUN cycle sees ph == 3.
    always_comb begin
        state_d = state_q;
        w_ready = 1'b0;
        x_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = reuse_ok ? SYNC : ALIGN;
                end
            end
            ALIGN: begin
                state_d = LOAD;
            end
            LOAD: begin
                w_ready = 1'b1;
                if (w_valid && last_word) begin
                    if (group_end) begin
                        state_d = (samp_left == '0) ? DRAIN : RUN;
                    end else begin
                        state_d = SYNC;
                    end
                end
            end
            SYNC: begin
                if (group_end) begin
                    state_d = (samp_left == '0) ? DRAIN : RUN;
                end
            end
            RUN: begin
                x_ready = (ph == 2'd3) || (ph == 2'd0);
                if (group_end && (samp_left == LEN_WIDTH'(1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ph tracks the cells' 4-phase machine, which restarts whenever arr_rst is applied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph <= 2'd0;
        end else if (arr_rst) begin
            ph <= 2'd0;
        end else begin
            ph <= ph + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= '0;
            samp_left <= '0;
        end else if (accept_start) begin
            mode_q    <= cfg_mode;
            samp_left <= cfg_len;
        end else if ((state_q == RUN) && group_end) begin
            samp_left <= samp_left - LEN_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            idx_q <= '0;
        end else if (state_q != LOAD) begin
            row_q <= '0;
            idx_q <= '0;
        end else if (w_fire) begin
            if (idx_q == LAST_IDX) begin
                idx_q <= '0;
                row_q <= row_q + ROW_W'(1);
            end else begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_q <= DRAIN_LAST;
        end else if (state_q != DRAIN) begin
            drain_q <= DRAIN_LAST;
        end else if (drain_q != '0) begin
            drain_q <= drain_q - DRAIN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            arr_rst <= 1'b1;
        end else begin
            busy    <= (state_d != IDLE) && (state_d != DONE);
            done    <= (state_d == DONE);
            arr_rst <= (state_d == ALIGN);
        end
    end

    // Mode stays at 1 until the final weight strobe has reached the cells.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arr_mode <= '0;
        end else if (w_fire || (state_d == LOAD)) begin
            arr_mode <= MODE_WIDTH'(1);
        end else if (state_d inside {SYNC, RUN, DRAIN}) begin
            arr_mode <= mode_src;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arr_move_data  <= '0;
            arr_move_valid <= '0;
        end else if (w_fire) begin
            arr_move_data  <= w_data;
            arr_move_valid <= N_ROWS'(1) << row_q;
        end else begin
            arr_move_valid <= '0;
        end
    end

    // A missing sample is replaced by zero; the array is never stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arr_left     <= '0;
            err_underrun <= 1'b0;
        end else begin
            arr_left <= x_fire ? x_data : '0;
            if (accept_start) begin
                err_underrun <= 1'b0;
            end else if (x_miss) begin
                err_underrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sa_seq_ctrl.sv
// Randomized self-checking bench for sa_seq_ctrl against a cycle-timeline reference model.
`timescale 1ns/1ps
module tb_sa_seq_ctrl;

    localparam int DW    = 32;
    localparam int MW    = 1;
    localparam int NR    = 4;
    localparam int WPC   = 2;
    localparam int LW    = 16;
    localparam int DRAIN = NR + 3;
    localparam int NW    = NR * WPC;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [MW-1:0] cfg_mode;
    logic [LW-1:0] cfg_len;
    logic          busy;
    logic          done;
    logic [DW-1:0] w_data;
    logic          w_valid;
    logic          w_ready;
    logic [DW-1:0] x_data;
    logic          x_valid;
    logic          x_ready;
    logic          arr_rst;
    logic [MW-1:0] arr_mode;
    logic [DW-1:0] arr_left;
    logic [DW-1:0] arr_move_data;
    logic [NR-1:0] arr_move_valid;
    logic          err_underrun;

    int cmp_cnt  = 0;
    int fail_cnt = 0;
    bit prev_err = 1'b0;

    logic [31:0] basic_w [0:NW-1] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                       32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};

    sa_seq_ctrl #(
        .DATA_WIDTH(DW), .MODE_WIDTH(MW), .N_ROWS(NR), .WEIGHTS_PER_CELL(WPC),
        .LEN_WIDTH(LW), .DRAIN_CYCLES(DRAIN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_mode(cfg_mode), .cfg_len(cfg_len),
        .busy(busy), .done(done),
        .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
        .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
        .arr_rst(arr_rst), .arr_mode(arr_mode), .arr_left(arr_left),
        .arr_move_data(arr_move_data), .arr_move_valid(arr_move_valid),
        .err_underrun(err_underrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input int cyc, input logic [31:0] obs,
                               input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("[TB] FAIL %s@%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic checkResetValues(input string tag, input int cyc);
        checkOutput({tag, "_busy"}, cyc, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, cyc, 32'(done), 32'd0);
        checkOutput({tag, "_w_ready"}, cyc, 32'(w_ready), 32'd0);
        checkOutput({tag, "_x_ready"}, cyc, 32'(x_ready), 32'd0);
        checkOutput({tag, "_arr_rst"}, cyc, 32'(arr_rst), 32'd1);
        checkOutput({tag, "_arr_mode"}, cyc, 32'(arr_mode), 32'd0);
        checkOutput({tag, "_arr_left"}, cyc, arr_left, 32'd0);
        checkOutput({tag, "_move_data"}, cyc, arr_move_data, 32'd0);
        checkOutput({tag, "_move_valid"}, cyc, 32'(arr_move_valid), 32'd0);
        checkOutput({tag, "_err"}, cyc, 32'(err_underrun), 32'd0);
    endtask

    // One run: cycle 0 carries the start pulse; the expected timeline is built from the run's rules.
    task automatic applyStimulus(input int len, input logic [MW-1:0] mode, input int w_kind,
                                 input bit table_w, input int under_slot, input bit poke_start,
                                 input bit reset_in_run);
        bit          wv [256];
        logic [31:0] wd [256];
        bit          xv [256];
        logic [31:0] xd [256];
        int          acc_k [256];
        logic [31:0] wt [NW];
        int k, n, last_acc, ph_l, sync, r0, e0, d0, tend, u, rst_cyc;
        bit v, slot_prev, slot_now;
        logic [31:0] exp_left, exp_mv;

        for (int i = 0; i < 256; i++) begin
            wv[i] = 1'($urandom_range(0, 1));
            wd[i] = $urandom;
            xv[i] = 1'($urandom_range(0, 1));
            xd[i] = $urandom;
            acc_k[i] = -1;
        end
        for (int i = 0; i < NW; i++) wt[i] = table_w ? basic_w[i] : $urandom;

        k = 0;
        n = 2;
        while (k < NW) begin
            case (w_kind)
                0:       v = 1'b1;
                1:       v = ((n - 2) % 2) == 0;
                default: v = 1'($urandom_range(0, 1));
            endcase
            if (n - 2 >= 3 * NW) v = 1'b1;
            wv[n] = v;
            if (v) begin
                wd[n] = wt[k];
                acc_k[n] = k;
                k++;
            end
            n++;
        end
        last_acc = n - 1;
        ph_l = (last_acc - 2) % 4;
        sync = (6 - ph_l) % 4;
        r0   = last_acc + 1 + sync;
        e0   = r0 + 4 * len;
        d0   = e0 + DRAIN;
        tend = d0 + 3;

        for (int i = 0; i < len; i++) begin
            for (int h = 0; h < 2; h++) xv[r0 + 4 * i + h] = (under_slot != 2 * i + h);
        end
        u = (under_slot >= 0 && under_slot < 2 * len) ? r0 + 4 * (under_slot / 2) + under_slot % 2 : -1;
        rst_cyc = reset_in_run ? r0 + int'($urandom_range(0, 4 * len - 1)) : -1;

        for (int c = 0; c <= tend; c++) begin
            @(negedge clk);
            if (c == rst_cyc) begin
                rst_n = 1'b0;
                #1;
                checkResetValues("midrun_rst", c);
                start = 1'b0;
                w_valid = 1'b0;
                x_valid = 1'b0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                #1;
                checkOutput("rel_arr_rst_hi", c, 32'(arr_rst), 32'd1);
                @(negedge clk);
                checkOutput("rel_arr_rst_lo", c, 32'(arr_rst), 32'd0);
                checkOutput("rel_busy", c, 32'(busy), 32'd0);
                checkOutput("rel_err", c, 32'(err_underrun), 32'd0);
                prev_err = 1'b0;
                return;
            end

            slot_now  = (c >= r0) && (c < e0) && (((c - r0) % 4) < 2);
            slot_prev = (c >= 1) && (c - 1 >= r0) && (c - 1 < e0) && (((c - 1 - r0) % 4) < 2);
            exp_left  = (slot_prev && xv[c - 1]) ? xd[c - 1] : 32'd0;
            exp_mv    = (c >= 1 && acc_k[c - 1] >= 0) ? (32'd1 << (acc_k[c - 1] / WPC)) : 32'd0;

            checkOutput("busy", c, 32'(busy), 32'(c >= 1 && c < d0));
            checkOutput("done", c, 32'(done), 32'(c == d0));
            checkOutput("arr_rst", c, 32'(arr_rst), 32'(c == 1));
            checkOutput("w_ready", c, 32'(w_ready), 32'(c >= 2 && c <= last_acc));
            checkOutput("x_ready", c, 32'(x_ready), 32'(slot_now));
            checkOutput("arr_left", c, arr_left, exp_left);
            checkOutput("move_valid", c, 32'(arr_move_valid), exp_mv);
            if (exp_mv != 32'd0) checkOutput("move_data", c, arr_move_data, wt[acc_k[c - 1]]);
            checkOutput("err_underrun", c, 32'(err_underrun),
                        32'((c == 0) ? prev_err : (u >= 0 && c > u)));
            if (c >= 2 && c <= last_acc) checkOutput("mode_load", c, 32'(arr_mode), 32'd1);
            if (c >= last_acc + 2 && c <= d0) checkOutput("mode_run", c, 32'(arr_mode), 32'(mode));

            start    = (c == 0) || (poke_start && c == 4);
            cfg_len  = (c == 0) ? LW'(len) : LW'($urandom);
            cfg_mode = (c == 0) ? mode : MW'($urandom_range(0, 1));
            w_valid  = wv[c];
            w_data   = wd[c];
            x_valid  = xv[c];
            x_data   = xd[c];
        end
        start = 1'b0;
        prev_err = (u >= 0);
    endtask

    initial begin
        int s;
        rst_n    = 1'b0;
        start    = 1'b0;
        cfg_mode = '0;
        cfg_len  = '0;
        w_valid  = 1'b0;
        w_data   = '0;
        x_valid  = 1'b0;
        x_data   = '0;

        repeat (3) @(negedge clk);
        checkResetValues("reset", 0);
        rst_n = 1'b1;
        #1;
        checkOutput("release_arr_rst_hi", 0, 32'(arr_rst), 32'd1);
        @(negedge clk);
        checkOutput("release_arr_rst_lo", 1, 32'(arr_rst), 32'd0);
        checkOutput("release_busy", 1, 32'(busy), 32'd0);
        checkOutput("release_move_valid", 1, 32'(arr_move_valid), 32'd0);

        $display("[TB] basic run");
        applyStimulus(3, 1'b0, 0, 1'b1, -1, 1'b0, 1'b0);
        $display("[TB] weight back-pressure");
        applyStimulus(2, 1'b1, 1, 1'b0, -1, 1'b0, 1'b0);
        $display("[TB] underrun on sample 1 real");
        applyStimulus(3, 1'b1, 0, 1'b0, 2, 1'b0, 1'b0);
        $display("[TB] zero length with start while busy");
        applyStimulus(0, 1'b0, 2, 1'b0, -1, 1'b1, 1'b0);
        $display("[TB] reset during run");
        applyStimulus(4, 1'b1, 2, 1'b0, -1, 1'b0, 1'b1);
        $display("[TB] run after reset");
        applyStimulus(3, 1'b0, 2, 1'b1, -1, 1'b0, 1'b0);
        $display("[TB] random runs");
        for (int r = 0; r < 5; r++) begin
            s = int'($urandom_range(0, 15));
            applyStimulus(int'($urandom_range(1, 6)), MW'($urandom_range(0, 1)),
                          int'($urandom_range(0, 2)), 1'b0, (s < 8) ? s : -1,
                          1'($urandom_range(0, 1)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
